// File: rtl/const_issue_gate.sv
// const_issue_gate: single-entry issue gate that holds one block descriptor,
// queries the constant scoreboard for read/write collisions, reserves the
// written constants once the query is clean, and then presents the descriptor
// downstream. Stall cycles spent waiting on a collision are counted.
module const_issue_gate #(
  parameter int NUM_CONSTANT_REGS = 32,
  parameter int TAG_W             = 8,
  parameter int CNT_W             = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CONSTANT_REGS-1:0] in_rd_map,
  input  logic [NUM_CONSTANT_REGS-1:0] in_wr_map,
  input  logic [TAG_W-1:0]             in_tag,
  input  logic                         flush,
  output logic                         sb_rd_valid,
  output logic [NUM_CONSTANT_REGS-1:0] sb_rd_map,
  input  logic                         sb_collision,
  output logic                         sb_rsv_valid,
  output logic [NUM_CONSTANT_REGS-1:0] sb_rsv_map,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CONSTANT_REGS-1:0] out_rd_map,
  output logic [NUM_CONSTANT_REGS-1:0] out_wr_map,
  output logic [TAG_W-1:0]             out_tag,
  output logic [CNT_W-1:0]             stall_cycles
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [NUM_CONSTANT_REGS-1:0] rd_q, rd_d;
  logic [NUM_CONSTANT_REGS-1:0] wr_q, wr_d;
  logic [TAG_W-1:0]             tag_q, tag_d;
  logic [CNT_W-1:0]             stall_q, stall_d;
  logic                         rsv_fire;

  // Next-state: descriptor capture, collision wait, reserve, issue and drop.
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    tag_d    = tag_q;
    stall_d  = stall_q;
    rsv_fire = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_valid) begin
          rd_d    = in_rd_map;
          wr_d    = in_wr_map;
          tag_d   = in_tag;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          // Drop before any reservation exists; nothing to undo downstream.
          rd_d    = '0;
          wr_d    = '0;
          tag_d   = '0;
          state_d = ST_EMPTY;
        end else if (!sb_collision) begin
          rsv_fire = 1'b1;
          state_d  = ST_ISSUE;
        end else if (stall_q != {CNT_W{1'b1}}) begin
          stall_d = stall_q + CNT_W'(1);
        end
      end
      ST_ISSUE: begin
        // Flush is ignored here: the constants are already reserved.
        if (out_ready) begin
          if (in_valid) begin
            rd_d    = in_rd_map;
            wr_d    = in_wr_map;
            tag_d   = in_tag;
            state_d = ST_WAIT;
          end else begin
            rd_d    = '0;
            wr_d    = '0;
            tag_d   = '0;
            state_d = ST_EMPTY;
          end
        end
      end
      default: begin
        rd_d    = '0;
        wr_d    = '0;
        tag_d   = '0;
        state_d = ST_EMPTY;
      end
    endcase
  end

  // State, descriptor and stall counter registers; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      rd_q    <= '0;
      wr_q    <= '0;
      tag_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      tag_q   <= tag_d;
      stall_q <= stall_d;
    end
  end

  assign in_ready     = (state_q == ST_EMPTY) || ((state_q == ST_ISSUE) && out_ready);
  assign sb_rd_valid  = (state_q == ST_WAIT);
  assign sb_rd_map    = (state_q == ST_WAIT) ? (rd_q | wr_q) : '0;
  assign sb_rsv_valid = rsv_fire;
  assign sb_rsv_map   = rsv_fire ? wr_q : '0;
  assign out_valid    = (state_q == ST_ISSUE);
  assign out_rd_map   = (state_q == ST_EMPTY) ? '0 : rd_q;
  assign out_wr_map   = (state_q == ST_EMPTY) ? '0 : wr_q;
  assign out_tag      = (state_q == ST_EMPTY) ? '0 : tag_q;
  assign stall_cycles = stall_q;

endmodule
